four_bit_adder: RTL and testbench
=================================

FOUR_BIT_ADDER -- requirements
Module: four_bit_adder

Interface
REQ-001 Parameter WIDTH, default 4: operand and sum width; legal range 1..16; all behaviour below is stated for WIDTH=4.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 Port op_a, input, WIDTH: operand A, unsigned (two's complement for the overflow flag).
REQ-005 Port op_b, input, WIDTH: operand B, same encoding as op_a.
REQ-006 Port carry_in, input, 1: carry into bit 0.
REQ-007 Port in_valid, input, 1: operands and carry_in valid this cycle.
REQ-008 Port sum, output, WIDTH: registered low WIDTH bits of op_a + op_b + carry_in.
REQ-009 Port carry_out, output, 1: registered carry out of the MSB.
REQ-010 Port overflow, output, 1: registered signed overflow; carry into MSB XOR carry out of MSB.
REQ-011 Port zero, output, 1: registered flag, high when registered sum == 0.
REQ-012 Port out_valid, input-aligned output, 1: high when sum/carry_out/overflow/zero hold a new result.

Function
REQ-013 The datapath SHALL be a ripple-carry chain of WIDTH full-adder cells: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = carry_in.
REQ-014 {carry_out, sum} SHALL equal op_a + op_b + carry_in as a (WIDTH+1)-bit unsigned sum for all 2^(2*WIDTH+1) input combinations.
REQ-015 Latency SHALL be exactly one cycle: inputs sampled with in_valid=1 at edge N appear on outputs after edge N, with out_valid=1 for that cycle.
REQ-016 The block SHALL accept a new operation every cycle (throughput 1/cycle); no back-pressure, no ready signal.
REQ-017 When in_valid=0 at an edge, sum, carry_out, overflow and zero SHALL hold their previous values and out_valid SHALL be 0 for that cycle.
REQ-018 Wrap-around: 15+1+0 SHALL give sum=0, carry_out=1, zero=1; 15+15+1 SHALL give sum=15, carry_out=1.
REQ-019 overflow SHALL be 1 exactly when op_a and op_b have equal MSBs and the sum MSB differs (e.g. 7+1+0 -> sum=8, overflow=1, carry_out=0).
REQ-020 zero SHALL reflect only sum; carry_out=1 with sum=0 still gives zero=1.
REQ-021 Outputs SHALL be free of X whenever rst has been applied, regardless of X on inputs while in_valid=0.

Reset
REQ-022 While rst=1 at a rising edge: sum=0, carry_out=0, overflow=0, zero=1, out_valid=0 after that edge.
REQ-023 rst SHALL take priority over in_valid; an operation presented in the same cycle as rst is discarded.
REQ-024 Reset asserted mid-stream SHALL cancel only the result being captured at that edge; the first edge with rst=0 and in_valid=1 produces a normal result one cycle later.
REQ-025 No reset value SHALL depend on input values; no asynchronous path from rst to outputs.

Verification
REQ-026 Reset: rst=1 for 2 cycles with op_a=9, op_b=3, in_valid=1 -> sum=0, carry_out=0, zero=1, out_valid=0.
REQ-027 Basic: op_a=3, op_b=4, carry_in=1, in_valid=1 -> next cycle sum=8, carry_out=0, overflow=1, zero=0, out_valid=1.
REQ-028 Wrap: op_a=15, op_b=1, carry_in=0 -> sum=0, carry_out=1, zero=1, overflow=0; op_a=15, op_b=15, carry_in=1 -> sum=15, carry_out=1.
REQ-029 Hold: valid op 2+2+0 then in_valid=0 with op_a=15, op_b=15 for 3 cycles -> sum stays 4, out_valid 1 then 0,0,0.
REQ-030 Exhaustive: all 512 (op_a, op_b, carry_in) combinations back-to-back, one per cycle -> every result matches the reference sum in the following cycle; scoreboard reports 512 completed, 512 correct, 0 failed.
REQ-031 Mid-stream reset: continuous valid stream with rst pulsed one cycle -> exactly one result lost, outputs at reset values for one cycle, stream correct afterwards.

Source files
------------

// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder: one operation per cycle, one cycle latency,
// with carry, signed-overflow and zero flags aligned to a valid strobe.
module four_bit_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    // One full-adder cell: returns {carry_next, sum_bit}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic p;
        p = a ^ b;
        return {(a & b) | (c & p), p ^ c};
    endfunction

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             overflow_s;
    logic             zero_s;

    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;
    logic             valid_r;

    assign carry_s[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic [1:0] cell_s;
        assign cell_s         = full_add(op_a[i], op_b[i], carry_s[i]);
        assign sum_s[i]       = cell_s[0];
        assign carry_s[i + 1] = cell_s[1];
    end

    // Flags derived from the combinational sum before it is registered
    always_comb begin
        overflow_s = carry_s[WIDTH] ^ carry_s[WIDTH-1];
        zero_s     = (sum_s == {WIDTH{1'b0}});
    end

    // Result register: reset wins, idle cycles hold the previous result
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r      <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b1;
            valid_r    <= 1'b0;
        end else if (in_valid) begin
            sum_r      <= sum_s;
            carry_r    <= carry_s[WIDTH];
            overflow_r <= overflow_s;
            zero_r     <= zero_s;
            valid_r    <= 1'b1;
        end else begin
            sum_r      <= sum_r;
            carry_r    <= carry_r;
            overflow_r <= overflow_r;
            zero_r     <= zero_r;
            valid_r    <= 1'b0;
        end
    end

    assign sum       = sum_r;
    assign carry_out = carry_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: directed cases, exhaustive sweep,
// mid-stream reset and randomized traffic against an arithmetic reference.
module tb_four_bit_adder;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         carry_in = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         out_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    int m_sum  = 0;
    int m_co   = 0;
    int m_ov   = 0;
    int m_zero = 1;
    int m_vld  = 0;

    four_bit_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
        .in_valid  (in_valid),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare every output
    task automatic step(input int r, input int a, input int b, input int ci, input int v);
        int total;
        int msb_a;
        int msb_b;
        int msb_s;
        @(negedge clk);
        rst      = r[0];
        op_a     = a[W-1:0];
        op_b     = b[W-1:0];
        carry_in = ci[0];
        in_valid = v[0];
        @(posedge clk);
        if (r != 0) begin
            m_sum = 0; m_co = 0; m_ov = 0; m_zero = 1; m_vld = 0;
        end else if (v != 0) begin
            total  = a + b + ci;
            m_sum  = total % M;
            m_co   = total / M;
            msb_a  = a / (M / 2);
            msb_b  = b / (M / 2);
            msb_s  = m_sum / (M / 2);
            m_ov   = (msb_a == msb_b && msb_s != msb_a) ? 1 : 0;
            m_zero = (m_sum == 0) ? 1 : 0;
            m_vld  = 1;
        end else begin
            m_vld = 0;
        end
        #1;
        chk("sum", int'(sum), m_sum);
        chk("carry_out", int'(carry_out), m_co);
        chk("overflow", int'(overflow), m_ov);
        chk("zero", int'(zero), m_zero);
        chk("out_valid", int'(out_valid), m_vld);
    endtask

    initial begin
        int done;
        int good;
        int f0;
        int seen;
        int r;

        // reset for two cycles with a live operation presented
        step(1, 9, 3, 0, 1);
        step(1, 9, 3, 0, 1);
        chk("rst_sum", int'(sum), 0);
        chk("rst_co", int'(carry_out), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_vld", int'(out_valid), 0);

        // basic 3+4+1 = 8, signed overflow
        step(0, 3, 4, 1, 1);
        chk("basic_sum", int'(sum), 8);
        chk("basic_co", int'(carry_out), 0);
        chk("basic_ov", int'(overflow), 1);
        chk("basic_zero", int'(zero), 0);
        chk("basic_vld", int'(out_valid), 1);

        // wrap-around cases
        step(0, 15, 1, 0, 1);
        chk("wrap1_sum", int'(sum), 0);
        chk("wrap1_co", int'(carry_out), 1);
        chk("wrap1_zero", int'(zero), 1);
        chk("wrap1_ov", int'(overflow), 0);
        step(0, 15, 15, 1, 1);
        chk("wrap2_sum", int'(sum), 15);
        chk("wrap2_co", int'(carry_out), 1);
        step(0, 7, 1, 0, 1);
        chk("ov71_sum", int'(sum), 8);
        chk("ov71_ov", int'(overflow), 1);
        chk("ov71_co", int'(carry_out), 0);

        // hold while idle
        step(0, 2, 2, 0, 1);
        chk("hold_first_vld", int'(out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 15, 15, 1, 0);
            chk("hold_sum", int'(sum), 4);
            chk("hold_vld", int'(out_valid), 0);
        end

        // exhaustive sweep, back-to-back
        done = 0;
        good = 0;
        for (int k = 0; k < 2 * M * M; k++) begin
            f0 = n_fail;
            step(0, k % M, (k / M) % M, k / (M * M), 1);
            done++;
            if (n_fail == f0) good++;
        end
        $display("exhaustive: %0d completed, %0d correct, %0d bad", done, good, done - good);
        chk("exh_done", done, 512);
        chk("exh_good", good, 512);

        // mid-stream reset pulse in a continuous valid stream
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            r = (i == 10) ? 1 : 0;
            step(r, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                 int'($urandom_range(0, 1)), 1);
            if (out_valid) seen++;
            if (i == 10) begin
                chk("mid_rst_sum", int'(sum), 0);
                chk("mid_rst_zero", int'(zero), 1);
                chk("mid_rst_vld", int'(out_valid), 0);
            end
        end
        chk("mid_rst_seen", seen, 19);

        // randomized traffic with idle gaps and occasional reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 31) == 0) ? 1 : 0,
                 int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                 int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
